// File: rtl/uart_pattern_responder_pkg.sv
// Shared types and helpers for the command matcher / reply generator.
package uart_pattern_responder_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned DROP_W = 8;

    typedef enum logic {
        StIdle,
        StSend
    } state_e;

    // ASCII a..z to A..Z; every other byte passes through unchanged.
    function automatic logic [BYTE_W-1:0] fold_upper(input logic [BYTE_W-1:0] b);
        if (b >= 8'h61 && b <= 8'h7a) begin
            return {b[7:6], 1'b0, b[4:0]};
        end
        return b;
    endfunction

endpackage

// File: rtl/uart_pattern_responder_if.sv
// Receive strobe and transmit valid/ready handshake between the UART and the responder.
interface uart_pattern_responder_if;
    import uart_pattern_responder_pkg::*;

    logic [BYTE_W-1:0] rx_data;
    logic              rx_valid;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (
        output rx_data, rx_valid, tx_ready,
        input  tx_data, tx_valid
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready,
        output tx_data, tx_valid
    );
endinterface

// File: rtl/uart_byte_window.sv
// Sliding window over the last CMD_LEN received bytes with fill tracking and idle timeout.
// window_o / full_o show the contents the window takes at the next edge.
module uart_byte_window
    import uart_pattern_responder_pkg::*;
#(
    parameter int unsigned CMD_LEN        = 5,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BYTE_W-1:0]         byte_i,
    input  logic                      valid_i,
    output logic [BYTE_W*CMD_LEN-1:0] window_o,
    output logic                      full_o
);

    localparam int unsigned WIN_W  = BYTE_W * CMD_LEN;
    localparam int unsigned FILL_W = $clog2(CMD_LEN + 1);

    logic [WIN_W-1:0]  window_q, window_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [WIN_W-1:0]  shifted;
    logic              expire;

    if (CMD_LEN > 1) begin : g_shift
        assign shifted = {window_q[WIN_W-BYTE_W-1:0], byte_i};
    end else begin : g_single
        assign shifted = byte_i;
    end

    if (TIMEOUT_CYCLES > 0) begin : g_timeout
        localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
        logic [IDLE_W-1:0] idle_q, idle_d;

        // Counter parks at TIMEOUT_CYCLES so the clear fires once per idle period.
        always_comb begin
            idle_d = idle_q;
            expire = 1'b0;
            if (valid_i) begin
                idle_d = '0;
            end else if (idle_q != IDLE_W'(TIMEOUT_CYCLES)) begin
                idle_d = idle_q + IDLE_W'(1);
                expire = (idle_d == IDLE_W'(TIMEOUT_CYCLES));
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                idle_q <= '0;
            end else begin
                idle_q <= idle_d;
            end
        end
    end else begin : g_no_timeout
        assign expire = 1'b0;
    end

    // A byte arriving on the expiry cycle takes priority over the clear.
    always_comb begin
        window_d = window_q;
        fill_d   = fill_q;
        if (valid_i) begin
            window_d = shifted;
            if (fill_q != FILL_W'(CMD_LEN)) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end else if (expire) begin
            window_d = '0;
            fill_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_q <= '0;
            fill_q   <= '0;
        end else begin
            window_q <= window_d;
            fill_q   <= fill_d;
        end
    end

    assign window_o = window_d;
    assign full_o   = (fill_d == FILL_W'(CMD_LEN));

endmodule

// File: rtl/uart_pattern_responder.sv
// Matches CMD in the received byte stream and streams RSP to the transmitter.
// Define PATTERN_CASE_FOLD_EN to fold received lower-case letters before matching.
module uart_pattern_responder
    import uart_pattern_responder_pkg::*;
#(
    parameter int unsigned          CMD_LEN        = 5,
    parameter int unsigned          RSP_LEN        = 4,
    parameter logic [8*CMD_LEN-1:0] CMD            = "MARCO",
    parameter logic [8*RSP_LEN-1:0] RSP            = "POLO",
    parameter int unsigned          TIMEOUT_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_pattern_responder_if.slave bus,
    output logic                   match,
    output logic                   busy,
    output logic [DROP_W-1:0]      drop_count
);

    localparam int unsigned      IDX_W    = (RSP_LEN > 1) ? $clog2(RSP_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RSP_LEN - 1);

    logic [BYTE_W-1:0]         rx_byte;
    logic [BYTE_W*CMD_LEN-1:0] window;
    logic                      full;
    logic                      hs;
    logic                      last_hs;
    logic [BYTE_W-1:0]         rsp_byte;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                pending_q, pending_d;
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic                match_q, match_d;

`ifdef PATTERN_CASE_FOLD_EN
    assign rx_byte = fold_upper(bus.rx_data);
`else
    assign rx_byte = bus.rx_data;
`endif

    uart_byte_window #(
        .CMD_LEN        (CMD_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .byte_i   (rx_byte),
        .valid_i  (bus.rx_valid),
        .window_o (window),
        .full_o   (full)
    );

    // Compare against the post-shift window so SEND starts the cycle after the last byte.
    assign match_d = bus.rx_valid && full && (window == CMD);
    assign hs      = (state_q == StSend) && bus.tx_ready;
    assign last_hs = hs && (idx_q == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            pending_q <= 1'b0;
            drop_q    <= '0;
            match_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            drop_q    <= drop_d;
            match_q   <= match_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        drop_d    = drop_q;
        unique case (state_q)
            StIdle: begin
                if (match_d) begin
                    state_d = StSend;
                    idx_d   = '0;
                end
            end
            StSend: begin
                if (last_hs) begin
                    // The finishing reply frees its slot, so a coincident match is never dropped.
                    idx_d     = '0;
                    state_d   = (pending_q || match_d) ? StSend : StIdle;
                    pending_d = pending_q && match_d;
                end else begin
                    if (hs) begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    if (match_d) begin
                        if (!pending_q) begin
                            pending_d = 1'b1;
                        end else if (drop_q != '1) begin
                            drop_d = drop_q + DROP_W'(1);
                        end
                    end
                end
            end
        endcase
    end

    always_comb begin
        rsp_byte = '0;
        for (int unsigned i = 0; i < RSP_LEN; i++) begin
            if (idx_q == IDX_W'(i)) begin
                rsp_byte = RSP[BYTE_W*(RSP_LEN-1-i) +: BYTE_W];
            end
        end
    end

    always_comb begin
        bus.tx_valid = (state_q == StSend);
        bus.tx_data  = (state_q == StSend) ? rsp_byte : '0;
        busy         = (state_q == StSend) || pending_q;
        match        = match_q;
        drop_count   = drop_q;
    end

endmodule

// File: tb/tb_uart_pattern_responder.sv
// Randomised and directed scoreboard bench for uart_pattern_responder (timeout set to 100).
module tb_uart_pattern_responder;

    localparam int unsigned CMD_LEN = 5;
    localparam int unsigned RSP_LEN = 4;
    localparam int unsigned TIMEOUT = 100;

    typedef struct {
        int         cyc;
        logic       valid;
        logic       busy;
        logic [7:0] drop;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       match;
    logic       busy;
    logic [7:0] drop_count;

    uart_pattern_responder_if bus_if ();

    uart_pattern_responder #(
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if),
        .match      (match),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int cyc        = 0;
    int n_checks   = 0;
    int n_fail     = 0;
    int match_seen = 0;
    int hs_seen    = 0;

    exp_t       exp_q[$];
    int         exp_match_q[$];
    logic [7:0] exp_byte_q[$];

    // Reference model: recent bytes since the last clear, and replies owed to the transmitter.
    logic [7:0] hist[$];
    int         idle_cnt = 0;
    int         owed     = 0;
    int         pos      = 0;
    int         drop_exp = 0;

    logic [8*CMD_LEN-1:0] cmd_str = "MARCO";
    logic [8*RSP_LEN-1:0] rsp_str = "POLO";

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] model_fold(input logic [7:0] b);
`ifdef PATTERN_CASE_FOLD_EN
        if (b >= "a" && b <= "z") return b - 8'd32;
`endif
        return b;
    endfunction

    task automatic model_step(input logic v, input logic [7:0] b, input logic rdy,
                              input logic r);
        exp_t e;
        logic m;
        logic hs;
        logic done;
        m = 1'b0;
        if (r) begin
            hist.delete();
            idle_cnt = 0;
            owed     = 0;
            pos      = 0;
            drop_exp = 0;
        end else begin
            if (v) begin
                hist.push_back(model_fold(b));
                if (hist.size() > CMD_LEN) void'(hist.pop_front());
                idle_cnt = 0;
                if (hist.size() == CMD_LEN) begin
                    m = 1'b1;
                    for (int i = 0; i < CMD_LEN; i++) begin
                        if (hist[i] != cmd_str[8*(CMD_LEN-1-i) +: 8]) m = 1'b0;
                    end
                end
            end else if (idle_cnt < TIMEOUT) begin
                idle_cnt++;
                if (idle_cnt == TIMEOUT) hist.delete();
            end
            hs   = (owed > 0) && rdy;
            done = hs && (pos == RSP_LEN - 1);
            if (hs) pos = done ? 0 : pos + 1;
            if (done) owed--;
            if (m) begin
                exp_match_q.push_back(cyc + 1);
                if (owed < 2) begin
                    owed++;
                    for (int i = 0; i < RSP_LEN; i++) begin
                        exp_byte_q.push_back(rsp_str[8*(RSP_LEN-1-i) +: 8]);
                    end
                end else if (drop_exp < 255) begin
                    drop_exp++;
                end
            end
        end
        e.cyc   = cyc + 1;
        e.valid = (owed > 0);
        e.busy  = (owed > 0);
        e.drop  = 8'(drop_exp);
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [7:0] b, input logic rdy, input logic r);
        exp_t e;
        @(posedge clk);
        #1;
        if (r && !rst) begin
            // Asynchronous reset takes effect in the current cycle.
            if (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc == cyc) begin
                void'(exp_q.pop_back());
                e.cyc   = cyc;
                e.valid = 1'b0;
                e.busy  = 1'b0;
                e.drop  = 8'h00;
                exp_q.push_back(e);
            end
            if (exp_match_q.size() > 0 && exp_match_q[exp_match_q.size()-1] == cyc) begin
                void'(exp_match_q.pop_back());
            end
            exp_byte_q.delete();
        end
        rst             = r;
        bus_if.rx_valid = v;
        bus_if.rx_data  = b;
        bus_if.tx_ready = rdy;
        model_step(v, b, rdy, r);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00, rdy, 1'b0);
    endtask

    task automatic send_str(input string s, input logic rdy);
        for (int i = 0; i < s.len(); i++) drive(1'b1, s[i], rdy, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_valid"}, bus_if.tx_valid, 0);
        check({tag, "_tx_data"}, bus_if.tx_data, 0);
        check({tag, "_match"}, match, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_drop"}, drop_count, 0);
    endtask

    // Monitor: compares every cycle against what the stimulus side predicted.
    always @(negedge clk) begin
        logic exp_m;
        exp_t e;
        exp_m = 1'b0;
        if (exp_match_q.size() > 0 && exp_match_q[0] == cyc) begin
            exp_m = 1'b1;
            void'(exp_match_q.pop_front());
        end
        check("match", match, exp_m);
        if (match) match_seen++;
        if (bus_if.tx_valid) begin
            if (exp_byte_q.size() == 0) begin
                check("tx_unexpected", bus_if.tx_valid, 0);
            end else begin
                check("tx_data", bus_if.tx_data, exp_byte_q[0]);
                if (bus_if.tx_ready) void'(exp_byte_q.pop_front());
            end
            if (bus_if.tx_ready) hs_seen++;
        end
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) void'(exp_q.pop_front());
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            check("tx_valid", bus_if.tx_valid, e.valid);
            check("busy", busy, e.busy);
            check("drop_count", drop_count, e.drop);
        end
    end

    initial begin
        int    m0;
        int    h0;
        string tok;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        bus_if.tx_ready = 1'b0;

        repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b1);
        #1;
        check_reset_outputs("reset");
        idle(2, 1'b1);

        // Basic command.
        m0 = match_seen;
        h0 = hs_seen;
        send_str("MARCO", 1'b1);
        idle(8, 1'b1);
        check("basic_matches", match_seen - m0, 1);
        check("basic_bytes", hs_seen - h0, 4);
        check("basic_end_valid", bus_if.tx_valid, 0);
        check("basic_end_busy", busy, 0);

        // Backpressure and overlapping commands.
        m0 = match_seen;
        h0 = hs_seen;
        for (int i = 0; i < 11; i++) begin
            tok = "xMARCOMARCO";
            drive(1'b1, tok[i], (i >= 10), 1'b0);
        end
        idle(12, 1'b1);
        check("overlap_matches", match_seen - m0, 2);
        check("overlap_bytes", hs_seen - h0, 8);
        check("overlap_drop", drop_count, 0);

        // Three commands while stalled: one is dropped.
        m0 = match_seen;
        h0 = hs_seen;
        send_str("MARCOMARCOMARCO", 1'b0);
        idle(3, 1'b0);
        idle(15, 1'b1);
        check("drop_matches", match_seen - m0, 3);
        check("drop_bytes", hs_seen - h0, 8);
        check("drop_count_one", drop_count, 1);

        // Timeout: 100 idle cycles clear the partial window, 99 do not.
        m0 = match_seen;
        send_str("MAR", 1'b1);
        idle(100, 1'b1);
        send_str("CO", 1'b1);
        idle(8, 1'b1);
        check("timeout_100_matches", match_seen - m0, 0);
        m0 = match_seen;
        send_str("MAR", 1'b1);
        idle(99, 1'b1);
        send_str("CO", 1'b1);
        idle(8, 1'b1);
        check("timeout_99_matches", match_seen - m0, 1);

        // Lower-case command.
        m0 = match_seen;
        h0 = hs_seen;
        send_str("marco", 1'b1);
        idle(8, 1'b1);
`ifdef PATTERN_CASE_FOLD_EN
        check("fold_matches", match_seen - m0, 1);
        check("fold_bytes", hs_seen - h0, 4);
`else
        check("fold_matches", match_seen - m0, 0);
        check("fold_bytes", hs_seen - h0, 0);
`endif

        // Random traffic with random backpressure.
        for (int t = 0; t < 120; t++) begin
            case ($urandom_range(0, 4))
                0:       tok = "MARCO";
                1:       tok = "marco";
                2:       tok = "MARCOMARCO";
                3:       tok = "xMAR";
                default: tok = "CO";
            endcase
            for (int i = 0; i < tok.len(); i++) begin
                drive(1'b1, tok[i], ($urandom_range(0, 3) != 0), 1'b0);
                if ($urandom_range(0, 7) == 0) drive(1'b0, 8'h00, 1'b1, 1'b0);
            end
            repeat ($urandom_range(0, 3)) drive(1'b0, 8'h00, ($urandom_range(0, 1) != 0), 1'b0);
        end
        idle(30, 1'b1);
        check("drain_bytes_left", exp_byte_q.size(), 0);
        check("drain_busy", busy, 0);

        // Reset in the middle of a reply.
        h0 = hs_seen;
        send_str("MARCO", 1'b1);
        idle(2, 1'b1);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        #1;
        check_reset_outputs("midreset");
        check("midreset_bytes_before", hs_seen - h0, 2);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        h0 = hs_seen;
        idle(10, 1'b1);
        check("midreset_bytes_after", hs_seen - h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
